// File: rtl/ps2_pkg.sv
// Shared scan-code/ASCII constants, receive FSM states and the game-key lookup.
package ps2_pkg;

    // Scan-code set 2 make codes for the game keys, plus the prefix bytes
    localparam logic [7:0] SC_A     = 8'h1C;
    localparam logic [7:0] SC_D     = 8'h23;
    localparam logic [7:0] SC_W     = 8'h1D;
    localparam logic [7:0] SC_S     = 8'h1B;
    localparam logic [7:0] SC_BREAK = 8'hF0;
    localparam logic [7:0] SC_EXT   = 8'hE0;

    localparam logic [7:0] ASC_A = 8'd97;
    localparam logic [7:0] ASC_D = 8'd100;
    localparam logic [7:0] ASC_W = 8'd119;
    localparam logic [7:0] ASC_S = 8'd115;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } rx_state_e;

    typedef struct packed {
        logic       hit;
        logic [7:0] ascii;
    } key_map_t;

    // Translate a make code to ASCII; hit=0 for keys the game does not use
    function automatic key_map_t map_key(input logic [7:0] code);
        key_map_t m;
        m.hit   = 1'b1;
        m.ascii = 8'd0;
        case (code)
            SC_A:    m.ascii = ASC_A;
            SC_D:    m.ascii = ASC_D;
            SC_W:    m.ascii = ASC_W;
            SC_S:    m.ascii = ASC_S;
            default: m.hit   = 1'b0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/ps2_rx_frame.sv
// PS/2 frame receiver: pin synchronisers, falling-edge detect, 11-bit frame
// FSM with odd-parity check and a mid-frame inactivity timeout.
module ps2_rx_frame
    import ps2_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] data_byte,
    output logic       byte_valid,
    output logic       err
);

    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    logic [1:0]      clk_sync;
    logic [1:0]      data_sync;
    logic            clk_prev;
    logic            fall;
    logic            din;

    rx_state_e       state, state_n;
    logic [2:0]      bit_cnt, bit_cnt_n;
    logic [7:0]      shreg, shreg_n;
    logic            par_err, par_err_n;
    logic [TO_W-1:0] to_cnt, to_cnt_n;
    logic            byte_valid_n, err_n;

    // Two-stage synchronisers plus one history bit for edge detection; idle-high
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_sync  <= 2'b11;
            data_sync <= 2'b11;
            clk_prev  <= 1'b1;
        end else begin
            clk_sync  <= {clk_sync[0], ps2_clk};
            data_sync <= {data_sync[0], ps2_data};
            clk_prev  <= clk_sync[1];
        end
    end

    assign fall      = clk_prev & ~clk_sync[1];
    assign din       = data_sync[1];
    assign data_byte = shreg;

    // Frame state register; pulses are registered so they are glitch-free
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            bit_cnt    <= 3'd0;
            shreg      <= 8'd0;
            par_err    <= 1'b0;
            to_cnt     <= '0;
            byte_valid <= 1'b0;
            err        <= 1'b0;
        end else begin
            state      <= state_n;
            bit_cnt    <= bit_cnt_n;
            shreg      <= shreg_n;
            par_err    <= par_err_n;
            to_cnt     <= to_cnt_n;
            byte_valid <= byte_valid_n;
            err        <= err_n;
        end
    end

    // Next-state: one bit consumed per synchronised falling edge
    always_comb begin
        state_n      = state;
        bit_cnt_n    = bit_cnt;
        shreg_n      = shreg;
        par_err_n    = par_err;
        to_cnt_n     = '0;
        byte_valid_n = 1'b0;
        err_n        = 1'b0;

        if (state != ST_IDLE && !fall)
            to_cnt_n = to_cnt + 1'b1;

        case (state)
            ST_IDLE: begin
                if (fall) begin
                    if (!din) begin
                        state_n   = ST_DATA;
                        bit_cnt_n = 3'd0;
                        par_err_n = 1'b0;
                    end else begin
                        err_n = 1'b1;
                    end
                end
            end
            ST_DATA: begin
                if (fall) begin
                    shreg_n   = {din, shreg[7:1]};
                    bit_cnt_n = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7)
                        state_n = ST_PARITY;
                end
            end
            ST_PARITY: begin
                // Data plus parity must hold an odd number of ones
                if (fall) begin
                    par_err_n = ~(^{din, shreg});
                    state_n   = ST_STOP;
                end
            end
            ST_STOP: begin
                if (fall) begin
                    if (din && !par_err)
                        byte_valid_n = 1'b1;
                    else
                        err_n = 1'b1;
                    state_n = ST_IDLE;
                end
            end
            default: state_n = ST_IDLE;
        endcase

        // Keyboard stalled mid-frame: drop the partial byte
        if (state != ST_IDLE && !fall && to_cnt == TO_LAST) begin
            state_n  = ST_IDLE;
            err_n    = 1'b1;
            to_cnt_n = '0;
        end
    end

endmodule

// File: rtl/ps2_key_decoder.sv
// Game-key decoder: turns received scan-code bytes into an ASCII key and a
// press counter, tracking break/extended prefixes and the held key.
module ps2_key_decoder
    import ps2_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int REPEAT_EN      = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] ps2_out,
    output logic [7:0] dataReg,
    output logic       key_valid,
    output logic       frame_err
);

    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       rx_err;

    logic       break_flag, break_flag_n;
    logic       ext_flag, ext_flag_n;
    logic [7:0] held, held_n;
    logic [7:0] ps2_out_n, dataReg_n;
    logic       key_valid_n;
    key_map_t   km;

    ps2_rx_frame #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_rx (
        .clk        (clk),
        .rst        (rst),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .data_byte  (rx_byte),
        .byte_valid (rx_valid),
        .err        (rx_err)
    );

    assign frame_err = rx_err;
    assign km        = map_key(rx_byte);

    // Decoder state and outputs; key and count always move together
    always_ff @(posedge clk) begin
        if (rst) begin
            break_flag <= 1'b0;
            ext_flag   <= 1'b0;
            held       <= 8'd0;
            ps2_out    <= 8'd0;
            dataReg    <= 8'd0;
            key_valid  <= 1'b0;
        end else begin
            break_flag <= break_flag_n;
            ext_flag   <= ext_flag_n;
            held       <= held_n;
            ps2_out    <= ps2_out_n;
            dataReg    <= dataReg_n;
            key_valid  <= key_valid_n;
        end
    end

    // Byte classification: prefixes set flags, releases clear held, makes count
    always_comb begin
        break_flag_n = break_flag;
        ext_flag_n   = ext_flag;
        held_n       = held;
        ps2_out_n    = ps2_out;
        dataReg_n    = dataReg;
        key_valid_n  = 1'b0;

        if (rx_valid) begin
            if (rx_byte == SC_BREAK) begin
                break_flag_n = 1'b1;
            end else if (rx_byte == SC_EXT) begin
                ext_flag_n = 1'b1;
            end else if (ext_flag) begin
                // Extended keys (arrows etc.) are not game keys, make or break
                ext_flag_n   = 1'b0;
                break_flag_n = 1'b0;
            end else if (break_flag) begin
                break_flag_n = 1'b0;
                if (rx_byte == held)
                    held_n = 8'd0;
            end else if (km.hit) begin
                if (!(REPEAT_EN == 0 && rx_byte == held)) begin
                    ps2_out_n   = km.ascii;
                    dataReg_n   = dataReg + 8'd1;
                    key_valid_n = 1'b1;
                    held_n      = rx_byte;
                end
            end
        end
    end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed bench: bit-banged PS/2 frames, checks on key, count and pulses.
module tb_ps2_key_decoder;

    localparam int TO = 2000;
    localparam int HALF = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rst_nr = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;

    logic [7:0] ps2_out, dataReg;
    logic       key_valid, frame_err;
    logic [7:0] nr_out, nr_cnt;
    logic       nr_valid, nr_err;

    int n_vec = 0;
    int n_err = 0;
    int kv_cnt = 0, fe_cnt = 0, both_cnt = 0, silent_cnt = 0;
    int kv0, fe0;
    logic [7:0] cnt_prev = 8'd0;

    ps2_key_decoder #(.TIMEOUT_CYCLES(TO), .REPEAT_EN(1)) dut (
        .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .ps2_out(ps2_out), .dataReg(dataReg), .key_valid(key_valid), .frame_err(frame_err)
    );

    ps2_key_decoder #(.TIMEOUT_CYCLES(TO), .REPEAT_EN(0)) dut_nr (
        .clk(clk), .rst(rst_nr), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .ps2_out(nr_out), .dataReg(nr_cnt), .key_valid(nr_valid), .frame_err(nr_err)
    );

    always #5 clk = ~clk;

    // Pulse monitors sampled away from the active edge
    always @(negedge clk) begin
        if (key_valid) kv_cnt++;
        if (frame_err) fe_cnt++;
        if (key_valid && frame_err) both_cnt++;
        if (!rst && dataReg != cnt_prev && !key_valid) silent_cnt++;
        cnt_prev = dataReg;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic ps2_bit(input logic b);
        ps2_data = b;
        cyc(HALF);
        ps2_clk = 1'b0;
        cyc(HALF);
        ps2_clk = 1'b1;
    endtask

    task automatic send(input logic [7:0] b, input logic flip);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit(~(^b) ^ flip);
        ps2_bit(1'b1);
        cyc(10);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc(3);
        rst = 1'b0;
        cyc(2);
    endtask

    task automatic mark();
        @(negedge clk);
        kv0 = kv_cnt;
        fe0 = fe_cnt;
    endtask

    initial begin
        // Reset values
        cyc(3);
        @(negedge clk);
        chk("rst_out", ps2_out, 0);
        chk("rst_cnt", dataReg, 0);
        chk("rst_kv", key_valid, 0);
        chk("rst_fe", frame_err, 0);
        rst = 1'b0;
        cyc(2);

        // Single press, then its release
        mark();
        send(8'h1C, 1'b0);
        @(negedge clk);
        chk("a_out", ps2_out, 97);
        chk("a_cnt", dataReg, 1);
        chk("a_pulses", kv_cnt - kv0, 1);
        mark();
        send(8'hF0, 1'b0);
        send(8'h1C, 1'b0);
        @(negedge clk);
        chk("a_brk_pulses", kv_cnt - kv0, 0);
        chk("a_brk_cnt", dataReg, 1);
        chk("a_brk_out", ps2_out, 97);

        // d, release d, w
        do_reset();
        mark();
        send(8'h23, 1'b0);
        @(negedge clk);
        chk("d_out", ps2_out, 100);
        chk("d_cnt", dataReg, 1);
        send(8'hF0, 1'b0);
        send(8'h23, 1'b0);
        send(8'h1D, 1'b0);
        @(negedge clk);
        chk("w_out", ps2_out, 119);
        chk("w_cnt", dataReg, 2);
        chk("dw_pulses", kv_cnt - kv0, 2);

        // Typematic repeat with and without REPEAT_EN
        rst = 1'b1; rst_nr = 1'b1;
        cyc(3);
        rst = 1'b0; rst_nr = 1'b0;
        cyc(2);
        repeat (3) send(8'h1C, 1'b0);
        @(negedge clk);
        chk("rep1_cnt", dataReg, 3);
        chk("rep0_cnt", nr_cnt, 1);
        chk("rep0_out", nr_out, 97);
        send(8'hF0, 1'b0);
        send(8'h1C, 1'b0);
        send(8'h1C, 1'b0);
        @(negedge clk);
        chk("rep0_repress", nr_cnt, 2);
        chk("rep1_repress", dataReg, 4);
        rst_nr = 1'b1;

        // Parity error and bad start bit
        do_reset();
        send(8'h1C, 1'b0);
        mark();
        send(8'h1C, 1'b1);
        @(negedge clk);
        chk("par_fe", fe_cnt - fe0, 1);
        chk("par_kv", kv_cnt - kv0, 0);
        chk("par_out", ps2_out, 97);
        chk("par_cnt", dataReg, 1);
        mark();
        ps2_bit(1'b1);
        cyc(10);
        @(negedge clk);
        chk("start_fe", fe_cnt - fe0, 1);
        send(8'h23, 1'b0);
        @(negedge clk);
        chk("start_idle_out", ps2_out, 100);
        chk("start_idle_cnt", dataReg, 2);

        // Timeout after four data bits
        mark();
        ps2_bit(1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(i[0]);
        ps2_data = 1'b1;
        cyc(TO + 100);
        @(negedge clk);
        chk("to_fe", fe_cnt - fe0, 1);
        chk("to_kv", kv_cnt - kv0, 0);
        send(8'h23, 1'b0);
        @(negedge clk);
        chk("to_next_out", ps2_out, 100);
        chk("to_next_cnt", dataReg, 3);

        // Extended code ignored, then counter wrap
        do_reset();
        mark();
        send(8'hE0, 1'b0);
        send(8'h1C, 1'b0);
        @(negedge clk);
        chk("ext_kv", kv_cnt - kv0, 0);
        chk("ext_out", ps2_out, 0);
        chk("ext_cnt", dataReg, 0);
        repeat (255) send(8'h1B, 1'b0);
        @(negedge clk);
        chk("wrap_255", dataReg, 255);
        send(8'h1B, 1'b0);
        @(negedge clk);
        chk("wrap_0", dataReg, 0);
        chk("wrap_out", ps2_out, 115);
        chk("wrap_pulses", kv_cnt - kv0, 256);

        // Reset in the middle of a frame
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b0);
        rst = 1'b1;
        cyc(3);
        @(negedge clk);
        chk("mrst_out", ps2_out, 0);
        chk("mrst_cnt", dataReg, 0);
        chk("mrst_kv", key_valid, 0);
        rst = 1'b0;
        cyc(2);
        send(8'h1D, 1'b0);
        @(negedge clk);
        chk("mrst_w_out", ps2_out, 119);
        chk("mrst_w_cnt", dataReg, 1);

        chk("kv_fe_overlap", both_cnt, 0);
        chk("silent_cnt_change", silent_cnt, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
